pixel_unpacker: RTL

PIXEL_UNPACKER -- requirements
Module: pixel_unpacker

---
 rtl/pixel_unpacker.sv | 134 +++++++++++++
 1 files changed

// File: rtl/pixel_unpacker.sv
// rtl/pixel_unpacker.sv - unpacks wide pixel FIFO words into one 24-bit RGB pixel per accepted cycle
module pixel_unpacker #(
  parameter int PIXEL_FIFO_DATA_WIDTH = 256,
  parameter int LANES = PIXEL_FIFO_DATA_WIDTH / 32
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             enable_i,
  input  logic                             flush_i,
  input  logic                             pixfifo_empty_i,
  output logic                             pixfifo_req_o,
  input  logic [PIXEL_FIFO_DATA_WIDTH-1:0] pixfifo_word_i,
  output logic                             pix_valid_o,
  input  logic                             pix_ready_i,
  output logic [23:0]                      pix_rgb_o,
  output logic [$clog2(LANES)-1:0]         pix_lane_o,
  output logic [15:0]                      underflow_cnt_o
);

  localparam int LW = $clog2(LANES);
  localparam logic [LW-1:0] LAST_LANE = LW'(LANES - 1);

  typedef enum logic {IDLE, RUN} state_e;

  state_e                   state_q, state_d;
  logic [LANES-1:0][23:0]   cur_q, cur_d, nxt_q, nxt_d;
  logic                     cur_vld_q, cur_vld_d;
  logic                     nxt_vld_q, nxt_vld_d;
  logic                     pend_q, pend_d;
  logic [LW-1:0]            lane_q, lane_d;
  logic [15:0]              ucnt_q, ucnt_d;

  logic [LANES-1:0][23:0]   word_rgb;
  logic [LANES-1:0][7:0]    unused_pad_bits;
  logic                     unused_pad;
  logic [1:0]               occupancy;
  logic                     req;
  logic                     accept;
  logic                     retire;
  logic                     flush_all;

  // Split the incoming word into its RGB lanes; the top byte of each slot is dropped.
  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      word_rgb[k]        = pixfifo_word_i[32*k +: 24];
      unused_pad_bits[k] = pixfifo_word_i[32*k+24 +: 8];
    end
  end

  assign unused_pad = ^unused_pad_bits;

  // Request gating, handshake and flush decode for the current cycle.
  always_comb begin
    occupancy = {1'b0, cur_vld_q} + {1'b0, nxt_vld_q} + {1'b0, pend_q};
    req       = !rst_i && (state_q == RUN) && enable_i && !flush_i &&
                !pixfifo_empty_i && (occupancy < 2'd2);
    accept    = cur_vld_q && pix_ready_i;
    retire    = accept && (lane_q == LAST_LANE);
    // Leaving RUN discards everything exactly like an explicit flush.
    flush_all = flush_i || ((state_q == RUN) && !enable_i);
  end

  // Next-state: retire shifts NXT into CUR first, so returning data lands behind any older word.
  always_comb begin
    state_d   = enable_i ? RUN : IDLE;
    cur_d     = cur_q;
    cur_vld_d = cur_vld_q;
    nxt_d     = nxt_q;
    nxt_vld_d = nxt_vld_q;
    lane_d    = lane_q;
    pend_d    = req;
    ucnt_d    = ucnt_q;

    if (retire) begin
      cur_d     = nxt_q;
      cur_vld_d = nxt_vld_q;
      nxt_vld_d = 1'b0;
      lane_d    = '0;
    end else if (accept) begin
      lane_d = lane_q + 1'b1;
    end

    if (pend_q) begin
      if (!cur_vld_d) begin
        cur_d     = word_rgb;
        cur_vld_d = 1'b1;
      end else begin
        nxt_d     = word_rgb;
        nxt_vld_d = 1'b1;
      end
    end

    if (flush_all) begin
      cur_vld_d = 1'b0;
      nxt_vld_d = 1'b0;
      pend_d    = 1'b0;
      lane_d    = '0;
    end

    if ((state_q == RUN) && pix_ready_i && !cur_vld_q && (ucnt_q != 16'hFFFF)) begin
      ucnt_d = ucnt_q + 16'd1;
    end
  end

  // All state registers, cleared by the synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      cur_q     <= '0;
      nxt_q     <= '0;
      cur_vld_q <= 1'b0;
      nxt_vld_q <= 1'b0;
      pend_q    <= 1'b0;
      lane_q    <= '0;
      ucnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      cur_q     <= cur_d;
      nxt_q     <= nxt_d;
      cur_vld_q <= cur_vld_d;
      nxt_vld_q <= nxt_vld_d;
      pend_q    <= pend_d;
      lane_q    <= lane_d;
      ucnt_q    <= ucnt_d;
    end
  end

  assign pixfifo_req_o   = req;
  assign pix_valid_o     = cur_vld_q;
  assign pix_rgb_o       = cur_q[lane_q];
  assign pix_lane_o      = lane_q;
  assign underflow_cnt_o = ucnt_q;

endmodule
